// File: rtl/huffman_table_loader.sv
// huffman_table_loader
// Turns the serialized Huffman code-table header (count byte, then
// {character, {length, path[11:8]}, path[7:0]} triples) into one entry at a
// time for the table-register stage. Each entry is held on length/character/
// path with enable high until the stage answers with save_comp.
module huffman_table_loader #(
   parameter int MAX_LEN = 12,
   parameter int PATH_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [3:0]        length,
   output logic [7:0]        character,
   output logic [PATH_W-1:0] path,
   output logic              enable,
   input  logic              save_comp,
   output logic [8:0]        entries_loaded,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_CHAR  = 3'd2,
      S_HI    = 3'd3,
      S_LO    = 3'd4,
      S_WRITE = 3'd5,
      S_DONE  = 3'd6,
      S_ERROR = 3'd7
   } state_t;

   state_t     state_r;
   logic [8:0] remaining_r;
   logic       xfer_s;

   // A code length is usable only if it is non-zero and fits the decoder.
   function automatic logic len_legal(input logic [3:0] len);
      return (len != 4'd0) && (len <= MAX_LEN_C);
   endfunction

   // A header byte moves only when both sides agree in the same cycle.
   assign xfer_s = in_valid && in_ready;

   // Header parser FSM; every output is a register updated with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= S_IDLE;
         remaining_r    <= 9'd0;
         in_ready       <= 1'b0;
         enable         <= 1'b0;
         length         <= 4'd0;
         character      <= 8'd0;
         path           <= '0;
         entries_loaded <= 9'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         // done is a single-cycle pulse; only the final save raises it
         done <= 1'b0;
         case (state_r)
            S_IDLE, S_ERROR: begin
               if (start) begin
                  state_r        <= S_COUNT;
                  in_ready       <= 1'b1;
                  busy           <= 1'b1;
                  entries_loaded <= 9'd0;
                  error          <= 1'b0;
               end
            end
            S_COUNT: begin
               if (xfer_s) begin
                  // a count byte of zero stands for a full 256-entry table
                  remaining_r <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                  state_r     <= S_CHAR;
               end
            end
            S_CHAR: begin
               if (xfer_s) begin
                  character <= in_data;
                  state_r   <= S_HI;
               end
            end
            S_HI: begin
               if (xfer_s) begin
                  length     <= in_data[7:4];
                  path[11:8] <= in_data[3:0];
                  if (len_legal(in_data[7:4])) begin
                     state_r <= S_LO;
                  end else begin
                     // stop consuming; the entry is never offered downstream
                     state_r  <= S_ERROR;
                     error    <= 1'b1;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                  end
               end
            end
            S_LO: begin
               if (xfer_s) begin
                  path[7:0] <= in_data;
                  state_r   <= S_WRITE;
                  in_ready  <= 1'b0;
                  enable    <= 1'b1;
               end
            end
            S_WRITE: begin
               // fields stay frozen until the table stage confirms the store
               if (save_comp) begin
                  enable      <= 1'b0;
                  remaining_r <= remaining_r - 9'd1;
                  if (entries_loaded != 9'd256) begin
                     entries_loaded <= entries_loaded + 9'd1;
                  end
                  if (remaining_r == 9'd1) begin
                     state_r <= S_DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     state_r  <= S_CHAR;
                     in_ready <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
            end
            default: begin
               state_r  <= S_IDLE;
               in_ready <= 1'b0;
               enable   <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_huffman_table_loader.sv
// Self-checking bench for huffman_table_loader: table-driven single-entry
// vectors, hand-written corner sequences and randomized loads compared with
// a byte-stream parsing model.
module tb_huffman_table_loader;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, save_comp;
   logic [7:0]  in_data;
   logic        in_ready, enable, busy, done, error;
   logic [3:0]  length;
   logic [7:0]  character;
   logic [11:0] path;
   logic [8:0]  entries_loaded;

   huffman_table_loader #(.MAX_LEN(12), .PATH_W(12)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .length(length), .character(character), .path(path),
      .enable(enable), .save_comp(save_comp),
      .entries_loaded(entries_loaded), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  ch;
      logic [3:0]  len;
      logic [11:0] path;
   } ent_t;

   typedef struct {
      logic [7:0]  ch;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [3:0]  exp_len;
      logic [11:0] exp_path;
      bit          exp_err;
   } vec_t;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] bq[$];
   logic [7:0] stream[$];
   ent_t       cap[$];
   ent_t       exp_q[$];
   bit         exp_err;
   int         done_cnt;
   vec_t       vt[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Parse the header bytes directly into the list of entries it describes.
   function automatic void model();
      int n;
      int p;
      logic [3:0] l;
      exp_q.delete();
      exp_err = 1'b0;
      if (stream.size() == 0) return;
      n = (stream[0] == 8'd0) ? 256 : int'(stream[0]);
      p = 1;
      for (int i = 0; i < n; i++) begin
         if (p + 1 >= stream.size()) break;
         l = stream[p+1][7:4];
         if (l == 4'd0 || l > 4'd12) begin
            exp_err = 1'b1;
            break;
         end
         if (p + 2 >= stream.size()) break;
         exp_q.push_back({stream[p], l, stream[p+1][3:0], stream[p+2]});
         p += 3;
      end
   endfunction

   task automatic compare_results(input string tag);
      check({tag, "_n_entries"}, 64'(cap.size()), 64'(exp_q.size()));
      for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
         check({tag, "_entry"}, 64'(cap[i]), 64'(exp_q[i]));
      check({tag, "_error"}, 64'(error), 64'(exp_err));
      check({tag, "_entries_loaded"}, 64'(entries_loaded), 64'(exp_q.size()));
      check({tag, "_done_pulses"}, 64'(done_cnt), exp_err ? 64'd0 : 64'd1);
   endtask

   // gap<0: random in_valid; sd<0: random save_comp delay (and stray save_comp).
   task automatic run_load(input string tag, input int gap, input int sd,
                           input bit rnd_start, input int budget);
      int gap_cnt, wait_cnt, sd_eff, last_save, tail;
      bit fin, prev_en, prev_saved;
      logic [32:0] prev_f;
      cap.delete();
      done_cnt = 0; gap_cnt = 0; wait_cnt = 0; last_save = -10; tail = 0;
      fin = 1'b0; prev_en = 1'b0; prev_saved = 1'b0; prev_f = '0;
      sd_eff = (sd < 0) ? int'($urandom_range(0, 3)) : sd;
      stream = bq;
      model();
      @(negedge clk);
      start = 1'b1; in_valid = 1'b0; save_comp = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
      check({tag, "_error_cleared"}, 64'(error), 64'd0);
      check({tag, "_count_cleared"}, 64'(entries_loaded), 64'd0);
      for (int cyc = 0; cyc < budget && tail < 3; cyc++) begin
         if (done) begin
            done_cnt++;
            check({tag, "_done_timing"}, 64'(cyc), 64'(last_save + 1));
            check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
         end
         if (enable) begin
            check({tag, "_in_ready_in_write"}, 64'(in_ready), 64'd0);
            if (prev_en && !prev_saved)
               check({tag, "_hold_fields"}, 64'({character, length, path, entries_loaded}), 64'(prev_f));
         end
         if (done || error) fin = 1'b1;
         if (fin) begin
            tail++;
            check({tag, "_no_accept_after_end"}, 64'(in_ready), 64'd0);
         end
         prev_f  = {character, length, path, entries_loaded};
         prev_en = enable;
         // byte lane
         in_data  = 8'($urandom_range(0, 255));
         in_valid = 1'b0;
         if (gap_cnt > 0) begin
            gap_cnt--;
         end else if (bq.size() > 0) begin
            in_data  = bq[0];
            in_valid = (gap < 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (in_valid && in_ready) begin
            void'(bq.pop_front());
            gap_cnt = (gap < 0) ? 0 : gap;
         end
         // table-stage lane
         if (enable) begin
            save_comp = (wait_cnt >= sd_eff);
            wait_cnt++;
            if (save_comp) begin
               cap.push_back({character, length, path});
               last_save = cyc;
               wait_cnt  = 0;
               if (sd < 0) sd_eff = int'($urandom_range(0, 3));
            end
         end else begin
            save_comp = (sd < 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            wait_cnt  = 0;
         end
         prev_saved = enable && save_comp;
         start = rnd_start && busy && ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end
      check({tag, "_finished_in_budget"}, 64'(fin), 64'd1);
      in_valid = 1'b0; save_comp = 1'b0; start = 1'b0;
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
      compare_results(tag);
      bq.delete();
   endtask

   initial begin
      int n;
      logic [3:0] l;
      logic [32:0] hold_f;

      vt[0] = '{8'h41, 8'h35, 8'hA0, 4'd3,  12'h5A0, 1'b0};
      vt[1] = '{8'h00, 8'h10, 8'h00, 4'd1,  12'h000, 1'b0};
      vt[2] = '{8'hFF, 8'hCF, 8'hFF, 4'd12, 12'hFFF, 1'b0};
      vt[3] = '{8'h7E, 8'hD0, 8'h12, 4'd0,  12'h000, 1'b1};
      vt[4] = '{8'h20, 8'h00, 8'h55, 4'd0,  12'h000, 1'b1};
      vt[5] = '{8'h33, 8'hF3, 8'h00, 4'd0,  12'h000, 1'b1};
      vt[6] = '{8'h99, 8'hA5, 8'h5A, 4'd10, 12'h55A, 1'b0};

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; save_comp = 1'b0; in_data = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_outputs", 64'({in_ready, enable, length, character, path,
                                  entries_loaded, busy, done, error}), 64'd0);

      // single-entry vectors; error cases are followed by a restart from ERROR
      for (int i = 0; i < 7; i++) begin
         bq = '{8'd1, vt[i].ch, vt[i].b1, vt[i].b2};
         run_load("vec", 0, 0, 1'b0, 200);
         check("vec_error_flag", 64'(error), 64'(vt[i].exp_err));
         check("vec_entry_count", 64'(cap.size()), vt[i].exp_err ? 64'd0 : 64'd1);
         if (!vt[i].exp_err && cap.size() > 0)
            check("vec_fields", 64'(cap[0]), 64'({vt[i].ch, vt[i].exp_len, vt[i].exp_path}));
      end

      // backpressure: table stage waits 5 cycles per entry
      bq = '{8'd3, 8'h10, 8'h21, 8'h22, 8'h11, 8'h43, 8'h44, 8'h12, 8'hC5, 8'h66};
      run_load("backpressure", 0, 5, 1'b0, 400);

      // three idle cycles between every byte
      bq = '{8'd4, 8'h61, 8'h12, 8'h34, 8'h62, 8'h56, 8'h78,
             8'h63, 8'h9A, 8'hBC, 8'h64, 8'h1F, 8'hFF};
      run_load("gaps", 3, 1, 1'b0, 600);

      // count byte 0 means 256 entries
      bq.delete();
      bq.push_back(8'd0);
      for (int i = 0; i < 256; i++) begin
         bq.push_back(8'(i));
         bq.push_back({4'((i % 12) + 1), 4'(i)});
         bq.push_back(8'(i * 37));
      end
      run_load("full256", 0, 0, 1'b0, 3000);

      // randomized tables with random valid gaps, save delays, stray starts
      for (int r = 0; r < 8; r++) begin
         bq.delete();
         n = int'($urandom_range(1, 10));
         bq.push_back(8'(n));
         for (int e = 0; e < n; e++) begin
            if ($urandom_range(0, 15) == 0)
               l = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(13, 15));
            else
               l = 4'($urandom_range(1, 12));
            bq.push_back(8'($urandom_range(0, 255)));
            bq.push_back({l, 4'($urandom_range(0, 15))});
            bq.push_back(8'($urandom_range(0, 255)));
         end
         run_load("random", -1, -1, 1'b1, 100 + n * 80);
      end

      // reset while an entry is being offered
      bq = '{8'd2, 8'h41, 8'h35, 8'hA0, 8'h42, 8'h35, 8'hA1};
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 40 && !enable && bq.size() > 0; c++) begin
         in_valid = 1'b1;
         in_data  = bq[0];
         if (in_ready) void'(bq.pop_front());
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("mid_enable_reached", 64'(enable), 64'd1);
      check("mid_fields", 64'({character, length, path}), 64'({8'h41, 4'd3, 12'h5A0}));
      hold_f = {character, length, path, entries_loaded};
      repeat (5) begin
         @(negedge clk);
         check("stall_hold", 64'({character, length, path, entries_loaded, in_ready, enable}),
               64'({hold_f, 1'b0, 1'b1}));
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_outputs", 64'({in_ready, enable, length, character, path,
                                    entries_loaded, busy, done, error}), 64'd0);
      in_valid = 1'b1; in_data = 8'h05;
      repeat (3) begin
         @(negedge clk);
         check("idle_after_rst", 64'({in_ready, busy, enable}), 64'd0);
      end
      in_valid = 1'b0;

      // reset and start in the same cycle: reset wins
      start = 1'b1; rst = 1'b1;
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      check("rst_beats_start", 64'({busy, in_ready}), 64'd0);

      bq = '{8'd1, 8'h41, 8'h35, 8'hA0};
      run_load("after_rst", 0, 0, 1'b0, 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/huffman_table_loader.md
Name: huffman_table_loader

Overview:
- Parses the serialized Huffman code-table header arriving from the byte input stream into per-symbol entries (character, code length, code path).
- Presents each entry to the downstream table-register stage on its `length`/`character`/`path`/`enable` interface.
- Advances only when that stage returns its save-complete indication.
- Sits between the byte-input demultiplexer and the table registers. Fills the 256-entry decode table before payload decoding starts.

Parameters:
- MAX_LEN, 12, longest legal code length in bits; lengths 1..MAX_LEN are accepted.
- PATH_W, 12, width of the code path field.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a table load when in IDLE
- in_data  in  8  header byte stream
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  loader accepts in_data this cycle (a byte transfers when in_valid && in_ready)
- length  out  4  code length of the current entry, to the table stage
- character  out  8  symbol of the current entry
- path  out  PATH_W  code bits of the current entry, MSB-aligned as received
- enable  out  1  current entry is valid; table stage writes it
- save_comp  in  1  table stage has stored the entry
- entries_loaded  out  9  entries written since the last start (0..256)
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the last entry has been saved
- error  out  1  sticky; illegal length seen

Behaviour:
- Reset (synchronous, active-high; takes effect on the next clk edge and overrides everything, including a load in progress):
  - State goes to IDLE.
  - All outputs go to 0: in_ready, enable, length, character, path, entries_loaded, busy, done, error.
  - Internal remaining count goes to 0.
- Byte format:
  - Byte 0 is the entry count N; 0 encodes 256.
  - Each entry is then 3 bytes:
    - B0 = character
    - B1 = {length[3:0], path[11:8]}
    - B2 = path[7:0]
- States: IDLE, COUNT, CHAR, HI, LO, WRITE, DONE, ERROR.
  - IDLE: in_ready=0, busy=0.
    - On start: go to COUNT, clear entries_loaded, clear error.
    - Bytes presented in IDLE are not consumed.
  - COUNT: in_ready=1, busy=1.
    - On transfer: remaining = (in_data==0) ? 256 : in_data (9 bits).
    - Go to CHAR.
  - CHAR: in_ready=1. On transfer: latch character, go to HI.
  - HI: in_ready=1. On transfer: latch length = in_data[7:4] and path[11:8] = in_data[3:0].
    - If in_data[7:4]==0 or >MAX_LEN: go to ERROR.
    - Otherwise go to LO.
  - LO: in_ready=1. On transfer: latch path[7:0], go to WRITE.
  - WRITE: in_ready=0, enable=1. length/character/path are held stable from registers for as long as enable is high.
    - Wait indefinitely for save_comp. The table stage may assert save_comp in the same cycle enable rises; that counts as completion on that edge.
    - On save_comp: entries_loaded+1, remaining-1.
    - If remaining was 1: go to DONE. Otherwise go to CHAR.
    - enable drops on the following cycle, so enable is high for at least 1 cycle per entry.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
  - ERROR: error=1 (sticky), in_ready=0, enable=0, busy=0.
    - Leave only on start (to COUNT, error cleared) or rst.
    - entries_loaded keeps the count saved before the fault.
- Throughput: minimum 4 cycles per entry when in_valid stays high (3 byte cycles + 1 WRITE cycle with immediate save_comp).
- In CHAR/HI/LO, stall while in_valid=0; latched fields do not change.
- start outside IDLE/ERROR is ignored.
- save_comp outside WRITE is ignored.
- entries_loaded saturates at 256; the 9-bit width means it cannot wrap.
- Simultaneous start and rst: rst wins.

Test Plan:
- Single entry: rst, start, bytes 0x01, 0x41, 0x35, 0xA0, save_comp tied to enable.
  - Required: enable high for 1 cycle with character=0x41, length=3, path=0x5A0.
  - Then done pulses once; entries_loaded=1; busy=0.
- Count 0 encodes 256: 256 entries with incrementing characters.
  - Required: exactly 256 enable pulses; entries_loaded=256; done on the cycle after the last save_comp.
- Backpressure: hold save_comp=0 for 5 cycles during WRITE.
  - Required: enable and the fields stay constant; in_ready=0; nothing advances until save_comp=1.
- in_valid gaps: insert 3 idle cycles between bytes.
  - Required: the same entries are produced; no byte is lost or duplicated.
- Illegal length: an entry with B1=0xD0 (length 13), and separately B1=0x00.
  - Required: error=1 and no enable for that entry.
  - Restart with start: error clears and a valid table loads normally.
- Reset mid-load: assert rst while in WRITE with enable=1.
  - Required: next cycle enable=0, state IDLE, all outputs 0.
